// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control path for a mm:ss stopwatch. It conditions four raw front-panel inputs
// by synchronizing and debouncing them, and it derives a 1 Hz time base plus a
// 2 Hz adjust rate from the system clock. A RUN / PAUSED / ADJUST state machine
// then turns these into advance and clear strobes for an external time counter.
//
// Parameters
//   CLK_DIV    clock cycles per 1 Hz tick (even, >= 4)
//   DB_CYCLES  consecutive stable cycles needed to accept a new input level (>= 2)
//
// Ports
//   clock      single clock, rising edge
//   rst_n      synchronous, active-low reset
//   btn_pause  raw pause button, active-high (a press toggles pause)
//   btn_clr    raw clear button, active-high
//   sw_adj     raw adjust-mode switch
//   sw_sel     raw adjust-field select (0 = seconds, 1 = minutes)
//   cnt_en     one-cycle advance strobe to the time counter
//   clr        one-cycle clear strobe to the time counter
//   pause_o    registered "state is PAUSED" flag
//   adj_o      registered "state is ADJUST" flag
//   sel_o      registered debounced field select
//   blink      1 Hz square wave for blinking the field being adjusted
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int CLK_DIV   = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic cnt_en,
  output logic clr,
  output logic pause_o,
  output logic adj_o,
  output logic sel_o,
  output logic blink
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DB_CYCLES - 1);

  // Bit positions of the conditioned inputs.
  localparam int I_PAUSE = 0;
  localparam int I_CLR   = 1;
  localparam int I_ADJ   = 2;
  localparam int I_SEL   = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_t;

  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db_lvl;
  logic [1:0]      btn_q;      // previous debounced button levels, for edge detection
  logic [DB_W-1:0] db_cnt [4];

  logic [DIV_W-1:0] div;
  logic             tick1;
  logic             tick2;

  state_t state;
  state_t state_nxt;
  logic   pause_flag;
  logic   pause_nxt;
  logic   cnt_en_nxt;
  logic   pause_press;
  logic   clr_press;

  assign raw = {sw_sel, sw_adj, btn_clr, btn_pause};

  // ---------------------------------------------------------------------------
  // Synchronizers and debouncers. A level is accepted only after the
  // synchronized input has disagreed with it for DB_CYCLES cycles in a row;
  // any agreement restarts the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchronizer chain.
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      btn_q  <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset
      // explicitly; a stale count would let a half-finished debounce complete early.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      btn_q <= db_lvl[1:0];
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press events fire on the rising edge of the debounced level only.
  assign pause_press = db_lvl[I_PAUSE] & ~btn_q[I_PAUSE];
  assign clr_press   = db_lvl[I_CLR]   & ~btn_q[I_CLR];

  // ---------------------------------------------------------------------------
  // Time base. A clear restarts the second so the first advance after a clear
  // is a full second away.
  // ---------------------------------------------------------------------------
  assign tick1 = (div == DIV_MAX);
  assign tick2 = tick1 | (div == DIV_HALF);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      div   <= '0;
      blink <= 1'b0;
    end else begin
      if (clr_press || tick1) div <= '0;
      else                    div <= div + 1'b1;
      if (tick2) blink <= ~blink;
    end
  end

  // ---------------------------------------------------------------------------
  // State machine.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= RUN;
      pause_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      pause_flag <= pause_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pause_nxt  = pause_flag;
    state_nxt  = RUN;
    cnt_en_nxt = 1'b0;

    // The pause flag survives ADJUST so leaving adjust returns to where we were.
    if (pause_press && state != ADJUST) pause_nxt = ~pause_flag;

    if (db_lvl[I_ADJ])  state_nxt = ADJUST;
    else if (pause_nxt) state_nxt = PAUSED;
    else                state_nxt = RUN;

    // Qualify by the state being entered, so the cycle that leaves ADJUST
    // cannot emit a stray fast-rate advance.
    case (state_nxt)
      RUN:     cnt_en_nxt = tick1;
      ADJUST:  cnt_en_nxt = tick2;
      default: cnt_en_nxt = 1'b0;
    endcase

    if (clr_press) cnt_en_nxt = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_en  <= 1'b0;
      clr     <= 1'b0;
      pause_o <= 1'b0;
      adj_o   <= 1'b0;
    end else begin
      cnt_en  <= cnt_en_nxt;
      clr     <= clr_press;
      pause_o <= (state_nxt == PAUSED);
      adj_o   <= (state_nxt == ADJUST);
    end
  end

  // The debounced select level is itself a reset flop.
  assign sel_o = db_lvl[I_SEL];

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000000, giving clock cycles per 1 Hz tick; legal values are even and >= 4.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000000, giving the consecutive stable cycles required to accept a button level; legal values are >= 2.
REQ-003 Port clock: input, 1 bit; the single clock; all logic on its rising edge.
REQ-004 Port rst_n: input, 1 bit; synchronous, active-low reset.
REQ-005 Port btn_pause: input, 1 bit; raw, asynchronous pause button, active-high.
REQ-006 Port btn_clr: input, 1 bit; raw, asynchronous clear button, active-high.
REQ-007 Port sw_adj: input, 1 bit; raw adjust-mode switch.
REQ-008 Port sw_sel: input, 1 bit; raw adjust-field select switch (0 = seconds, 1 = minutes).
REQ-009 Port cnt_en: output, 1 bit; one-cycle advance strobe to the time counter.
REQ-010 Port clr: output, 1 bit; one-cycle clear strobe to the time counter.
REQ-011 Port pause_o: output, 1 bit; registered paused flag.
REQ-012 Port adj_o: output, 1 bit; registered adjust-mode flag.
REQ-013 Port sel_o: output, 1 bit; registered field select.
REQ-014 Port blink: output, 1 bit; 1 Hz square wave used for the adjust-field display blink.

Function
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer, followed by a debouncer per input.
REQ-016 Each debounced level SHALL update only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any mismatch break SHALL restart the count.
REQ-017 A press event SHALL be a one-cycle pulse on the cycle a debounced button level goes 0->1; no event SHALL occur on release.
REQ-018 The divider SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-019 tick1 SHALL be high when the divider = CLK_DIV-1.
REQ-020 tick2 SHALL be high when the divider = CLK_DIV/2-1 or CLK_DIV-1.
REQ-021 blink SHALL toggle on every tick2 cycle.
REQ-022 The state machine SHALL have states RUN, PAUSED and ADJUST.
REQ-023 The next state SHALL be ADJUST when the debounced adj level is 1; otherwise it SHALL be PAUSED when the pause flag is 1, else RUN.
REQ-024 A pause press SHALL toggle the pause flag in RUN and PAUSED, and SHALL be ignored in ADJUST; the flag SHALL be retained across ADJUST.
REQ-025 cnt_en SHALL be registered: tick1 in RUN, tick2 in ADJUST, and 0 in PAUSED; latency is 1 cycle after the tick.
REQ-026 pause_o SHALL equal (state == PAUSED).
REQ-027 adj_o SHALL equal (state == ADJUST).
REQ-028 sel_o SHALL equal the debounced sel level; all three are registered.
REQ-029 A clear press SHALL assert clr for exactly 1 cycle, 1 cycle after the event, and SHALL reset the divider to 0 on that same cycle.
REQ-030 cnt_en SHALL be forced to 0 on any cycle clr is 1.
REQ-031 Clear SHALL leave the pause flag, the state and blink unchanged.
REQ-032 When a clear press and a pause press occur in the same cycle, both SHALL take effect.
REQ-033 When sw_adj falls, the next state SHALL follow REQ-023 with no cnt_en glitch; a tick2 in the exit cycle SHALL NOT produce cnt_en.

Reset
REQ-034 When rst_n = 0 at a rising edge, the block SHALL set the following, with priority over all other activity, including mid-debounce and mid-divide:
- state RUN, pause flag 0, divider 0
- synchronizers, debounce counters and debounced levels 0
- cnt_en, clr, pause_o, adj_o, sel_o and blink all 0
REQ-035 After reset, the block SHALL produce no press event until an input has been high for DB_CYCLES cycles.

Verification (CLK_DIV=10, DB_CYCLES=3)
REQ-036 Release reset and hold inputs low for 40 cycles -> cnt_en pulses every 10 cycles and blink toggles every 5; pause_o = 0 and adj_o = 0.
REQ-037 Pulse btn_pause high for 2 cycles -> no event and state stays RUN; hold it high for 6 cycles -> PAUSED, cnt_en stays 0, and one more press returns the state to RUN.
REQ-038 Raise sw_adj while PAUSED -> adj_o = 1 and cnt_en every 5 cycles; a pause press while in ADJUST has no effect; lower sw_adj -> the state returns to PAUSED.
REQ-039 Press btn_clr with the divider at 7 -> clr is high for exactly 1 cycle, the divider restarts at 0, and the next cnt_en arrives 10 cycles after clr; a simultaneous pause press also toggles the pause flag.
REQ-040 Drive rst_n low for 1 cycle while in ADJUST with a debounce in progress -> all outputs are 0 and the state is RUN on the next cycle, with sw_adj still high; adj_o then reasserts only after 3 stable cycles plus the synchronizer delay.
